// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    // Width of the one-hot ALU control bus (one line per legal opcode).
    localparam int unsigned ALU_CTL_W = 13;

    // Opcode encoding; the bit position in alu_ctl equals the opcode value.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_DIV  = 4'd3,
        ALU_SHR  = 4'd4,
        ALU_SHRA = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_ROR  = 4'd7,
        ALU_ROL  = 4'd8,
        ALU_AND  = 4'd9,
        ALU_OR   = 4'd10,
        ALU_NEG  = 4'd11,
        ALU_NOT  = 4'd12
    } alu_op_e;

    // Highest legal opcode; anything above is illegal.
    localparam alu_op_e ALU_OP_LAST = ALU_NOT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Latency class selecting how long the ALU controls are held.
    typedef enum logic [1:0] {
        LAT_SINGLE = 2'd0,
        LAT_MUL    = 2'd1,
        LAT_DIV    = 2'd2
    } lat_class_e;

endpackage : alu_seq_pkg

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot ALU control, illegal flag and latency class.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0]           op_i,
    output logic [ALU_CTL_W-1:0] ctl_o,
    output logic                 illegal_o,
    output lat_class_e           lat_o
);

    // Decode the opcode; illegal codes produce no control line.
    always_comb begin
        ctl_o     = '0;
        illegal_o = 1'b0;
        lat_o     = LAT_SINGLE;
        if (op_i > 4'(ALU_OP_LAST)) begin
            illegal_o = 1'b1;
        end else begin
            ctl_o = ALU_CTL_W'(1) << op_i;
            if (op_i == 4'(ALU_MUL)) begin
                lat_o = LAT_MUL;
            end else if (op_i == 4'(ALU_DIV)) begin
                lat_o = LAT_DIV;
            end
        end
    end

endmodule : alu_op_decode

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer driving the shared 32-bit ALU: accepts one request, holds the
// one-hot ALU controls for the op's settle time, captures the 64-bit result and offers it
// on a valid/ready response port. The MUL/DIV combinational paths must be constrained as
// multicycle paths of MUL_WAIT/DIV_WAIT cycles to match the capture point below.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned MUL_WAIT = 4,
    parameter int unsigned DIV_WAIT = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [31:0]          req_a,
    input  logic [31:0]          req_b,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    input  logic [63:0]          alu_c,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_lo,
    output logic [31:0]          resp_hi,
    output logic                 resp_err,
    output logic                 busy
);

    seq_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        err_q, err_d;

    logic [3:0]           dec_op;
    logic [ALU_CTL_W-1:0] dec_ctl;
    logic                 dec_illegal;
    lat_class_e           dec_lat;

    // One decoder serves both phases: the incoming opcode while idle (for the accept
    // decision) and the latched opcode otherwise (for the control lines).
    assign dec_op = (state_q == IDLE) ? req_op : op_q;

    alu_op_decode u_decode (
        .op_i      (dec_op),
        .ctl_o     (dec_ctl),
        .illegal_o (dec_illegal),
        .lat_o     (dec_lat)
    );

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign resp_lo = lo_q;
    assign resp_hi = hi_q;
    assign resp_err = err_q;

    // Next-state and output logic of the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        alu_ctl    = '0;
        busy       = 1'b1;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (dec_illegal || (dec_lat == LAT_DIV && req_b == 32'd0)) begin
                        // Error responses skip the ALU entirely.
                        lo_d    = '0;
                        hi_d    = '0;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = EXEC;
                        unique case (dec_lat)
                            LAT_MUL: cnt_d = 8'(MUL_WAIT - 1);
                            LAT_DIV: cnt_d = 8'(DIV_WAIT - 1);
                            default: cnt_d = '0;
                        endcase
                    end
                end
            end
            EXEC: begin
                alu_ctl = dec_ctl;
                if (cnt_q == 8'd0) begin
                    {hi_d, lo_d} = alu_c;
                    err_d        = 1'b0;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, operand and result registers; clear aborts and zeroes everything.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a settle-time-aware ALU model.
module tb_alu_op_sequencer;

    localparam int unsigned MW = 4;
    localparam int unsigned DW = 8;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [31:0] alu_a, alu_b;
    logic [12:0] alu_ctl;
    logic [63:0] alu_c;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_lo, resp_hi;
    logic        resp_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    alu_op_sequencer #(.MUL_WAIT(MW), .DIV_WAIT(DW)) dut (
        .clock      (clock),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctl    (alu_ctl),
        .alu_c      (alu_c),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_lo    (resp_lo),
        .resp_hi    (resp_hi),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    // Arithmetic of the ALU, straight from the opcode table.
    function automatic logic [63:0] alu_fn(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] r;
        sh = int'(b[4:0]);
        r  = '0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  return {32'h0, a} * {32'h0, b};
            3:  return (b == 0) ? 64'h0 : {a % b, a / b};
            4:  r = a >> sh;
            5:  r = $unsigned($signed(a) >>> sh);
            6:  r = a << sh;
            7:  r = (a >> sh) | (a << (32 - sh));
            8:  r = (a << sh) | (a >> (32 - sh));
            9:  r = a & b;
            10: r = a | b;
            11: r = 32'd0 - a;
            12: r = ~a;
            default: r = '0;
        endcase
        return {32'h0, r};
    endfunction

    function automatic int settle(input int op);
        return (op == 2) ? int'(MW) : (op == 3) ? int'(DW) : 1;
    endfunction

    // ALU model: output is garbage until the control line has been held long enough.
    int          held = 0;
    logic [12:0] last_ctl = '0;
    always @(negedge clock) begin
        if (alu_ctl == 13'd0) held <= 0;
        else if (alu_ctl == last_ctl) held <= held + 1;
        else held <= 1;
        last_ctl <= alu_ctl;
    end

    always_comb begin
        alu_c = 64'hA5A5_5A5A_DEAD_BEEF;
        for (int i = 0; i < 13; i++) begin
            if (alu_ctl == (13'd1 << i) && held >= settle(i)) alu_c = alu_fn(i, alu_a, alu_b);
        end
    end

    // Reference model of the response {err, hi, lo}.
    function automatic logic [64:0] ref_resp(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        if (op > 4'd12 || (op == 4'd3 && b == 0)) return {1'b1, 64'h0};
        return {1'b0, alu_fn(int'(op), a, b)};
    endfunction

    function automatic bit is_err(input logic [3:0] op, input logic [31:0] b);
        return (op > 4'd12 || (op == 4'd3 && b == 0));
    endfunction

    // Edges after the accept edge t0 until resp_valid is seen: spec latency minus one.
    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        if (is_err(op, b)) return 1 - 1;
        if (op == 4'd2) return 1 + int'(MW) - 1;
        if (op == 4'd3) return 1 + int'(DW) - 1;
        return 2 - 1;
    endfunction

    function automatic int ref_ctl(input logic [3:0] op, input logic [31:0] b);
        if (is_err(op, b)) return 0;
        return settle(int'(op));
    endfunction

    // Drive one request and observe the response; called at a negedge with the DUT idle.
    task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int rdelay, input bit noise, input bit early,
                           output int lat, output int ctl_cycles, output bit ctl_bad,
                           output logic [31:0] lo, output logic [31:0] hi, output logic err,
                           output bit stable, output bit timeout);
        ctl_cycles = 0;
        ctl_bad    = 0;
        stable     = 1;
        timeout    = 0;
        lat        = 0;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        resp_ready = early;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        while (resp_valid !== 1'b1 && lat < 400) begin
            if (alu_ctl !== 13'd0) begin
                if (op <= 4'd12 && alu_ctl === (13'd1 << op)) ctl_cycles++;
                else ctl_bad = 1;
            end
            @(negedge clock);
            lat++;
        end
        if (resp_valid !== 1'b1) timeout = 1;
        if (alu_ctl !== 13'd0) ctl_bad = 1;
        lo  = resp_lo;
        hi  = resp_hi;
        err = resp_err;
        for (int i = 0; i < rdelay; i++) begin
            if (noise) begin
                req_valid = 1'b1;
                req_op    = 4'($urandom_range(0, 12));
                req_a     = $urandom;
                req_b     = $urandom;
            end
            @(negedge clock);
            if (resp_valid !== 1'b1 || resp_lo !== lo || resp_hi !== hi || resp_err !== err ||
                req_ready !== 1'b0 || busy !== 1'b1 || alu_ctl !== 13'd0) stable = 0;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL reset_handshake: req_ready=%b busy=%b resp_valid=%b, want 1 0 0",
                     req_ready, busy, resp_valid);
        else n_pass++;
        n_checks++;
        if (alu_ctl !== 13'd0 || alu_a !== 32'd0 || alu_b !== 32'd0)
            $display("FAIL reset_alu: ctl=%h a=%h b=%h, want all 0", alu_ctl, alu_a, alu_b);
        else n_pass++;
        n_checks++;
        if (resp_lo !== 32'd0 || resp_hi !== 32'd0 || resp_err !== 1'b0)
            $display("FAIL reset_resp: lo=%h hi=%h err=%b, want 0", resp_lo, resp_hi, resp_err);
        else n_pass++;
        clear = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_add();
        int lat, cc; bit bad, st, to; logic [31:0] lo, hi; logic err;
        run_txn(4'd0, 32'd5, 32'd7, 0, 0, 0, lat, cc, bad, lo, hi, err, st, to);
        n_checks++;
        if (to || lat != 1) $display("FAIL add_latency: got %0d edges, want 1", lat);
        else n_pass++;
        n_checks++;
        if (cc != 1 || bad) $display("FAIL add_ctl: %0d cycles bad=%b, want 1 cycle", cc, bad);
        else n_pass++;
        n_checks++;
        if (lo !== 32'd12 || hi !== 32'd0 || err !== 1'b0)
            $display("FAIL add_result: lo=%h hi=%h err=%b, want c 0 0", lo, hi, err);
        else n_pass++;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL add_release: req_ready=%b busy=%b resp_valid=%b, want 1 0 0",
                     req_ready, busy, resp_valid);
        else n_pass++;
    endtask

    task automatic test_mul();
        int lat, cc; bit bad, st, to; logic [31:0] lo, hi; logic err;
        run_txn(4'd2, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, lat, cc, bad, lo, hi, err, st, to);
        n_checks++;
        if (to || lat != int'(MW)) $display("FAIL mul_latency: got %0d edges, want %0d", lat, MW);
        else n_pass++;
        n_checks++;
        if (cc != int'(MW) || bad) $display("FAIL mul_ctl: %0d cycles bad=%b, want %0d", cc, bad, MW);
        else n_pass++;
        n_checks++;
        if (hi !== 32'd1 || lo !== 32'd0 || err !== 1'b0)
            $display("FAIL mul_result: hi=%h lo=%h err=%b, want 1 0 0", hi, lo, err);
        else n_pass++;
    endtask

    task automatic test_div();
        int lat, cc; bit bad, st, to; logic [31:0] lo, hi; logic err;
        run_txn(4'd3, 32'd17, 32'd5, 0, 0, 0, lat, cc, bad, lo, hi, err, st, to);
        n_checks++;
        if (to || lat != int'(DW) || cc != int'(DW) || bad)
            $display("FAIL div_timing: lat=%0d ctl=%0d bad=%b, want %0d %0d 0", lat, cc, bad, DW, DW);
        else n_pass++;
        n_checks++;
        if (lo !== 32'd3 || hi !== 32'd2 || err !== 1'b0)
            $display("FAIL div_result: lo=%h hi=%h err=%b, want 3 2 0", lo, hi, err);
        else n_pass++;
        run_txn(4'd3, 32'd17, 32'd0, 0, 0, 0, lat, cc, bad, lo, hi, err, st, to);
        n_checks++;
        if (to || lat != 0 || cc != 0 || bad)
            $display("FAIL div0_timing: lat=%0d ctl=%0d bad=%b, want 0 0 0", lat, cc, bad);
        else n_pass++;
        n_checks++;
        if (err !== 1'b1 || lo !== 32'd0 || hi !== 32'd0)
            $display("FAIL div0_result: err=%b lo=%h hi=%h, want 1 0 0", err, lo, hi);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int lat, cc; bit bad, st, to; logic [31:0] lo, hi; logic err;
        run_txn(4'd14, 32'h1234_5678, 32'h9abc_def0, 0, 0, 0, lat, cc, bad, lo, hi, err, st, to);
        n_checks++;
        if (to || lat != 0 || cc != 0 || bad || err !== 1'b1 || lo !== 32'd0 || hi !== 32'd0)
            $display("FAIL illegal_op: lat=%0d ctl=%0d bad=%b err=%b lo=%h hi=%h, want 0 0 0 1 0 0",
                     lat, cc, bad, err, lo, hi);
        else n_pass++;
        run_txn(4'd1, 32'd3, 32'd5, 0, 0, 0, lat, cc, bad, lo, hi, err, st, to);
        n_checks++;
        if (to || lat != 1 || lo !== 32'hFFFF_FFFE || err !== 1'b0)
            $display("FAIL sub_after_illegal: lat=%0d lo=%h err=%b, want 1 fffffffe 0", lat, lo, err);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat, cc; bit bad, st, to; logic [31:0] lo, hi; logic err;
        run_txn(4'd8, 32'h8000_0001, 32'd4, 10, 1, 0, lat, cc, bad, lo, hi, err, st, to);
        n_checks++;
        if (to || lat != 1 || lo !== 32'h0000_0018 || hi !== 32'd0 || err !== 1'b0)
            $display("FAIL rol_result: lat=%0d lo=%h hi=%h err=%b, want 1 18 0 0", lat, lo, hi, err);
        else n_pass++;
        n_checks++;
        if (!st) $display("FAIL backpressure_stable: outputs moved while held, stable=%b want 1", st);
        else n_pass++;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL backpressure_release: req_ready=%b busy=%b resp_valid=%b, want 1 0 0",
                     req_ready, busy, resp_valid);
        else n_pass++;
    endtask

    task automatic test_clear();
        int lat, cc; bit bad, st, to; logic [31:0] lo, hi; logic err;
        req_op    = 4'd2;
        req_a     = 32'h0001_2345;
        req_b     = 32'h0000_6789;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1 || alu_ctl !== 13'd4)
            $display("FAIL clear_pre: busy=%b ctl=%h, want 1 0004", busy, alu_ctl);
        else n_pass++;
        clear = 1'b1;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || alu_ctl !== 13'd0 || busy !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL clear_abort: resp_valid=%b ctl=%h busy=%b req_ready=%b, want 0 0 0 1",
                     resp_valid, alu_ctl, busy, req_ready);
        else n_pass++;
        n_checks++;
        if (resp_lo !== 32'd0 || resp_hi !== 32'd0 || resp_err !== 1'b0 || alu_a !== 32'd0)
            $display("FAIL clear_zero: lo=%h hi=%h err=%b a=%h, want 0", resp_lo, resp_hi, resp_err,
                     alu_a);
        else n_pass++;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL clear_noresp: resp_valid=%b busy=%b, want 0 0", resp_valid, busy);
        else n_pass++;
        run_txn(4'd9, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 0, lat, cc, bad, lo, hi, err, st, to);
        n_checks++;
        if (to || lat != 1 || cc != 1 || bad || lo !== 32'h00F0_1234 || err !== 1'b0)
            $display("FAIL and_after_clear: lat=%0d ctl=%0d lo=%h err=%b, want 1 1 00f01234 0",
                     lat, cc, lo, err);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, cc, rd; bit bad, st, to, early; logic [31:0] lo, hi, a, b; logic err;
        logic [3:0] op; logic [64:0] exp;
        for (int i = 0; i < 60; i++) begin
            op    = 4'($urandom_range(0, 15));
            a     = $urandom;
            b     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 31));
            early = 1'($urandom_range(0, 1));
            rd    = early ? 0 : $urandom_range(0, 3);
            exp   = ref_resp(op, a, b);
            run_txn(op, a, b, rd, 1'($urandom_range(0, 1)), early, lat, cc, bad, lo, hi, err, st, to);
            n_checks++;
            if (to || lat != ref_lat(op, b) || cc != ref_ctl(op, b) || bad || !st)
                $display("FAIL rand_timing[%0d] op=%0d: lat=%0d ctl=%0d bad=%b st=%b, want %0d %0d 0 1",
                         i, op, lat, cc, bad, st, ref_lat(op, b), ref_ctl(op, b));
            else n_pass++;
            n_checks++;
            if ({err, hi, lo} !== exp)
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h, want %h",
                         i, op, a, b, {err, hi, lo}, exp);
            else n_pass++;
            n_checks++;
            if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
                $display("FAIL rand_release[%0d]: req_ready=%b busy=%b resp_valid=%b, want 1 0 0",
                         i, req_ready, busy, resp_valid);
            else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_illegal();
        test_backpressure();
        test_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_op_sequencer

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle sequencer in front of the shared 32-bit ALU. It accepts one operation request over a valid/ready handshake and registers the operands. It drives the ALU's one-hot control lines for the required number of cycles: one cycle for single-cycle ops, a parameterised settle time for the combinational MUL/DIV paths. It then captures the 64-bit result and presents it on a valid/ready response port. It sits between the control unit and the ALU, with the ALU instantiated alongside it at the datapath top level.

## Interface
Parameters:
- MUL_WAIT, 4, cycles ALU controls are held for MUL before capture (1..255)
- DIV_WAIT, 8, cycles ALU controls are held for DIV before capture (1..255)

Ports:
- clock  in  1  sole clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_op  in  4  opcode (package enum)
- req_a, req_b  in  32 each  operands
- alu_a, alu_b  out  32 each  registered operands to ALU
- alu_ctl  out  13  one-hot ALU controls, bit order = opcode order (ADD..NOT)
- alu_c  in  64  ALU result ({hi,lo}; DIV = {remainder,quotient})
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_lo, resp_hi  out  32 each  captured result halves
- resp_err  out  1  illegal opcode or divide-by-zero
- busy  out  1  high in any state but IDLE

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 AND, 10 OR, 11 NEG, 12 NOT. Codes 13–15 are illegal.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, a and b.
  - Illegal op → DONE with resp_err=1 and result 0.
  - DIV with req_b==0 → DONE with resp_err=1 and result 0; the ALU is never driven.
  - Otherwise → EXEC, with the 8-bit counter loaded to 0 (single-cycle ops), MUL_WAIT-1 or DIV_WAIT-1.
- EXEC:
  - alu_ctl is the one-hot of the latched op.
  - The counter decrements each cycle.
  - When the counter is 0, alu_c is captured into resp_hi/resp_lo on that edge, resp_err=0, next state DONE.
- DONE:
  - alu_ctl=0; resp_valid=1.
  - resp_hi/lo/err are held stable until resp_ready.
  - On resp_valid&resp_ready → IDLE.
- alu_ctl is all-zero outside EXEC; exactly one bit is set in EXEC.
- alu_a/alu_b always reflect the operand registers.
- No request queuing: req_ready=0 while busy, and requests presented then are ignored (they stay pending on the producer side).

## Timing
- Reset values: state IDLE; req_ready=1 (combinational from IDLE); resp_valid=0; busy=0; alu_ctl=0; alu_a, alu_b, resp_lo, resp_hi = 0; resp_err=0; counter=0.
- Let t0 be the accept edge. resp_valid rises at:
  - t0+2 for single-cycle ops;
  - t0+1+MUL_WAIT for MUL;
  - t0+1+DIV_WAIT for DIV;
  - t0+1 for error cases.
- Response handshake edge at t1 → IDLE; req_ready is high from t1. There is no same-cycle bypass, so the minimum request spacing is 3 cycles for single-cycle ops.
- resp_ready held low: the sequencer stays in DONE indefinitely, with outputs stable.
- resp_ready high before resp_valid has no effect.
- clear asserted mid-EXEC or in DONE: aborts immediately and asynchronously. No response is issued and the result registers are zeroed.
- MUL_WAIT/DIV_WAIT of 1 gives the same latency as a single-cycle op.
- MUL/DIV multicycle timing constraints must match MUL_WAIT/DIV_WAIT.

## Structure
- Package alu_seq_pkg holds:
  - alu_op_e, the 4-bit opcode enum, with ALU_OP_LAST=12;
  - seq_state_e (IDLE, EXEC, DONE);
  - the constant ALU_CTL_W=13.
- Sub-module alu_op_decode, purely combinational, maps an opcode to:
  - the 13-bit one-hot;
  - the illegal flag;
  - a latency-class select (single, mul, div).
- The sequencer holds the FSM, counter, operand and result registers, and the handshakes.

## Test plan
- ADD a=5, b=7, resp_ready=1 → resp_valid at t0+2; resp_lo=12, resp_hi=0; alu_ctl=13'b1 for exactly one cycle.
- MUL a=0x10000, b=0x10000, MUL_WAIT=4 → alu_ctl bit2 held 4 cycles; resp_hi=1, resp_lo=0 at t0+5.
- DIV a=17, b=5, DIV_WAIT=8 → resp_lo=3, resp_hi=2 at t0+9. DIV b=0 → resp_err=1, result 0 at t0+1, alu_ctl never nonzero.
- Opcode 14 → resp_err=1 at t0+1. A following SUB a=3, b=5 → resp_lo=0xFFFFFFFE, resp_err=0.
- Backpressure: resp_ready low 10 cycles after ROL completes → outputs stable, req_ready=0, a new req_valid is ignored. Raising resp_ready gives req_ready=1 the next cycle.
- clear pulse during MUL EXEC → next cycle IDLE, resp_valid=0, alu_ctl=0, result regs 0. A subsequent AND request completes normally.
